// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control plane: FSM encoding,
// debounce counter sizing and the Moore output decode.
package stopwatch_pkg;

    localparam int STATE_W        = 2;
    localparam int DEBOUNCE_CNT_W = 8;
    localparam int DEFAULT_DEBOUNCE_MS = 20;

    // Encoding is visible on the state port (debug LEDs), so values are fixed.
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    // Counter runs in RUN and LAP; LAP only freezes the display.
    function automatic logic state_enable(input state_t s);
        return (s == RUN) || (s == LAP);
    endfunction

    function automatic logic state_freeze(input state_t s);
        return (s == LAP);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton: 2-flop synchroniser, tick-based debounce counter and a
// registered single-cycle pulse on the accepted rising edge.
module button_debouncer
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS
) (
    input  logic clock,
    input  logic reset,
    input  logic tick,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = DEBOUNCE_CNT_W;
    localparam logic [CW:0] TARGET = (CW+1)'(DEBOUNCE_MS);

    logic [1:0]    sync_q;
    logic          stable_q;
    logic [CW-1:0] cnt_q;
    logic [CW:0]   cnt_inc;
    logic          differs;
    logic          accept;

    assign differs = (sync_q[1] != stable_q);
    assign cnt_inc = {1'b0, cnt_q} + (CW+1)'(1);
    // New level has been held for DEBOUNCE_MS ticks: this tick completes it.
    assign accept  = differs && tick && (cnt_inc == TARGET);

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], btn_raw};
    end

    // Count ticks while the synced level disagrees with the stable level;
    // any return to the stable level restarts the count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else if (!differs) begin
            cnt_q <= '0;
        end else if (tick) begin
            if (accept) begin
                stable_q <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_inc[CW-1:0];
            end
        end
    end

    // Pulse only when the stable level goes 0->1; releases are silent.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) press <= 1'b0;
        else       press <= accept && sync_q[1];
    end

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: debounces start/stop, lap and clear, then runs a
// Moore FSM driving counter enable, clear pulse, display freeze and lap count.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_MS = DEFAULT_DEBOUNCE_MS,
    parameter int unsigned LAP_W       = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick_1ms,
    input  logic               btn_start_stop,
    input  logic               btn_lap,
    input  logic               btn_clear,
    output logic               count_enable,
    output logic               count_clear,
    output logic               display_freeze,
    output logic [STATE_W-1:0] state,
    output logic [LAP_W-1:0]   lap_count
);

    localparam int NUM_BTN = 3;
    localparam int B_START = 0;
    localparam int B_LAP   = 1;
    localparam int B_CLEAR = 2;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;
    logic               start_p, lap_p, clear_p;

    state_t state_q, state_d;
    logic   clear_hit;
    logic   lap_hit;

    assign btn_raw[B_START] = btn_start_stop;
    assign btn_raw[B_LAP]   = btn_lap;
    assign btn_raw[B_CLEAR] = btn_clear;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_MS(DEBOUNCE_MS)
        ) u_deb (
            .clock  (clock),
            .reset  (reset),
            .tick   (tick_1ms),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    assign start_p = press[B_START];
    assign lap_p   = press[B_LAP];
    assign clear_p = press[B_CLEAR];

    // Next state from press pulses; the if/else order encodes the
    // per-state priority when pulses coincide.
    always_comb begin
        state_d   = state_q;
        clear_hit = 1'b0;
        lap_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_p)      state_d = RUN;
                else if (clear_p) clear_hit = 1'b1;
            end
            RUN: begin
                if (start_p) begin
                    state_d = PAUSE;
                end else if (lap_p) begin
                    state_d = LAP;
                    lap_hit = 1'b1;
                end
            end
            LAP: begin
                if (start_p)    state_d = PAUSE;
                else if (lap_p) state_d = RUN;
            end
            PAUSE: begin
                if (clear_p) begin
                    state_d   = IDLE;
                    clear_hit = 1'b1;
                end else if (start_p) begin
                    state_d = RUN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Outputs registered from the next state so they change on the same
    // edge as the state register; the clear pulse lines up with IDLE entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_enable   <= 1'b0;
            display_freeze <= 1'b0;
            count_clear    <= 1'b0;
        end else begin
            count_enable   <= state_enable(state_d);
            display_freeze <= state_freeze(state_d);
            count_clear    <= clear_hit;
        end
    end

    // Lap counter: saturating; cleared together with the counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lap_count <= '0;
        end else if (clear_hit) begin
            lap_count <= '0;
        end else if (lap_hit && (lap_count != {LAP_W{1'b1}})) begin
            lap_count <= lap_count + LAP_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Directed bench for stopwatch_controller: DEBOUNCE_MS=2, tick every 10 clocks.
module tb_stopwatch_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick_1ms = 1'b0;
    logic       btn_start_stop = 1'b0;
    logic       btn_lap = 1'b0;
    logic       btn_clear = 1'b0;
    logic       count_enable, count_clear, display_freeze;
    logic [1:0] state;
    logic [3:0] lap_count;

    int total = 0;
    int bad   = 0;
    int clr_cycles = 0;
    int tcnt = 0;

    stopwatch_controller #(.DEBOUNCE_MS(2), .LAP_W(4)) dut (
        .clock         (clock),
        .reset         (reset),
        .tick_1ms      (tick_1ms),
        .btn_start_stop(btn_start_stop),
        .btn_lap       (btn_lap),
        .btn_clear     (btn_clear),
        .count_enable  (count_enable),
        .count_clear   (count_clear),
        .display_freeze(display_freeze),
        .state         (state),
        .lap_count     (lap_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        tcnt     <= (tcnt == 9) ? 0 : tcnt + 1;
        tick_1ms <= (tcnt == 9);
    end

    // Total number of cycles count_clear was high; one per clear event.
    always @(negedge clock) if (count_clear === 1'b1) clr_cycles++;

    typedef struct {
        logic [2:0] btn;   // {clear, lap, start}
        int         ticks;
        logic [1:0] st;
        logic       en;
        logic       frz;
        logic [3:0] lc;
        int         clr;   // cumulative count_clear cycles
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic en,
                           input logic frz, input logic [3:0] lc, input int clr);
        chk({tag, ".state"}, 32'(state), 32'(st));
        chk({tag, ".enable"}, 32'(count_enable), 32'(en));
        chk({tag, ".freeze"}, 32'(display_freeze), 32'(frz));
        chk({tag, ".lap_count"}, 32'(lap_count), 32'(lc));
        chk({tag, ".clear_cycles"}, 32'(clr_cycles), 32'(clr));
    endtask

    // Hold the given buttons for a number of ticks, release, let it settle.
    task automatic press(input logic [2:0] m, input int ticks);
        @(posedge clock); #1;
        {btn_clear, btn_lap, btn_start_stop} = m;
        repeat (ticks * 10) @(posedge clock);
        #1;
        {btn_clear, btn_lap, btn_start_stop} = 3'b000;
        repeat (40) @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        //          btn     ticks st     en    frz   lc     clr
        vecs[0]  = '{3'b001, 1,  2'd0, 1'b0, 1'b0, 4'd0, 0}; // glitch: ignored
        vecs[1]  = '{3'b001, 3,  2'd1, 1'b1, 1'b0, 4'd0, 0}; // IDLE->RUN
        vecs[2]  = '{3'b001, 50, 2'd2, 1'b0, 1'b0, 4'd0, 0}; // long hold: one pulse
        vecs[3]  = '{3'b001, 3,  2'd1, 1'b1, 1'b0, 4'd0, 0}; // PAUSE->RUN
        vecs[4]  = '{3'b100, 3,  2'd1, 1'b1, 1'b0, 4'd0, 0}; // clear in RUN ignored
        vecs[5]  = '{3'b010, 3,  2'd3, 1'b1, 1'b1, 4'd1, 0}; // RUN->LAP
        vecs[6]  = '{3'b010, 3,  2'd1, 1'b1, 1'b0, 4'd1, 0}; // LAP->RUN
        vecs[7]  = '{3'b001, 3,  2'd2, 1'b0, 1'b0, 4'd1, 0}; // RUN->PAUSE
        vecs[8]  = '{3'b010, 3,  2'd2, 1'b0, 1'b0, 4'd1, 0}; // lap in PAUSE ignored
        vecs[9]  = '{3'b100, 3,  2'd0, 1'b0, 1'b0, 4'd0, 1}; // PAUSE->IDLE clear
        vecs[10] = '{3'b100, 3,  2'd0, 1'b0, 1'b0, 4'd0, 2}; // clear in IDLE pulses
        vecs[11] = '{3'b010, 3,  2'd0, 1'b0, 1'b0, 4'd0, 2}; // lap in IDLE ignored
        vecs[12] = '{3'b001, 3,  2'd1, 1'b1, 1'b0, 4'd0, 2}; // IDLE->RUN
        vecs[13] = '{3'b010, 3,  2'd3, 1'b1, 1'b1, 4'd1, 2}; // RUN->LAP
        vecs[14] = '{3'b100, 3,  2'd3, 1'b1, 1'b1, 4'd1, 2}; // clear in LAP ignored
        vecs[15] = '{3'b001, 3,  2'd2, 1'b0, 1'b0, 4'd1, 2}; // LAP->PAUSE
        vecs[16] = '{3'b001, 3,  2'd1, 1'b1, 1'b0, 4'd1, 2}; // PAUSE->RUN

        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("in_reset.clear", 32'(count_clear), 32'd0);
        chk_all("in_reset", 2'd0, 1'b0, 1'b0, 4'd0, 0);
        reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk_all("after_reset", 2'd0, 1'b0, 1'b0, 4'd0, 0);

        for (int i = 0; i < 17; i++) begin
            press(vecs[i].btn, vecs[i].ticks);
            chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].en, vecs[i].frz,
                    vecs[i].lc, vecs[i].clr);
        end

        // 20 RUN->LAP->RUN cycles: count saturates at 15, toggling continues.
        for (int i = 0; i < 40; i++) begin
            press(3'b010, 3);
            if (i == 38) chk_all("sat_lap", 2'd3, 1'b1, 1'b1, 4'd15, 2);
        end
        chk_all("sat_run", 2'd1, 1'b1, 1'b0, 4'd15, 2);

        // PAUSE: clear beats start, lap count zeroed.
        press(3'b001, 3);
        chk_all("to_pause", 2'd2, 1'b0, 1'b0, 4'd15, 2);
        press(3'b101, 3);
        chk_all("pause_clr_start", 2'd0, 1'b0, 1'b0, 4'd0, 3);

        // IDLE: start beats clear, no clear pulse.
        press(3'b101, 3);
        chk_all("idle_start_clr", 2'd1, 1'b1, 1'b0, 4'd0, 3);

        // RUN: start beats lap, lap count untouched.
        press(3'b010, 3);
        press(3'b010, 3);
        chk_all("lap_pair", 2'd1, 1'b1, 1'b0, 4'd1, 3);
        press(3'b011, 3);
        chk_all("run_start_lap", 2'd2, 1'b0, 1'b0, 4'd1, 3);

        // Bouncing lap button then settling high: exactly one lap pulse.
        press(3'b001, 3);
        chk_all("back_run", 2'd1, 1'b1, 1'b0, 4'd1, 3);
        @(posedge clock); #1;
        for (int i = 0; i < 7; i++) begin
            btn_lap = ~btn_lap;
            repeat (3) @(posedge clock);
            #1;
        end
        btn_lap = 1'b1;
        repeat (40) @(posedge clock);
        #1 btn_lap = 1'b0;
        repeat (40) @(posedge clock);
        @(negedge clock);
        chk_all("bounce", 2'd3, 1'b1, 1'b1, 4'd2, 3);

        // Asynchronous reset mid-cycle clears everything immediately.
        @(posedge clock); #3;
        reset = 1'b1;
        #1;
        chk("async_rst.state", 32'(state), 32'd0);
        chk("async_rst.enable", 32'(count_enable), 32'd0);
        chk("async_rst.freeze", 32'(display_freeze), 32'd0);
        chk("async_rst.lap_count", 32'(lap_count), 32'd0);
        chk("async_rst.clear", 32'(count_clear), 32'd0);
        repeat (3) @(posedge clock);
        #2 reset = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk_all("post_rst", 2'd0, 1'b0, 1'b0, 4'd0, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
